// File: rtl/core_response_checker.sv
// Response-side checker: expected bytes are queued in a FIFO and the core's output
// stream is compared against them in order, with saturating event counters.
module core_response_checker #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       exp_valid,
  input  logic [DATA_W-1:0]          exp_data,
  output logic                       exp_ready,
  input  logic                       obs_valid,
  input  logic [DATA_W-1:0]          obs_data,
  input  logic                       check_en,
  output logic [CNT_W-1:0]           match_cnt,
  output logic [CNT_W-1:0]           mismatch_cnt,
  output logic [CNT_W-1:0]           unexpected_cnt,
  output logic [$clog2(DEPTH):0]     pending,
  output logic                       error,
  output logic [DATA_W-1:0]          err_exp,
  output logic [DATA_W-1:0]          err_obs,
  output logic                       idle
);
  localparam int PTR_W = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, ARMED, FAIL} state_t;

  state_t                state_reg, state_next;
  logic [DATA_W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_reg, rd_ptr_reg;
  logic [PTR_W:0]        count_reg;

  logic                  res_valid_reg, res_unexp_reg;
  logic [DATA_W-1:0]     res_exp_reg, res_obs_reg;
  logic [DATA_W-1:0]     err_exp_reg, err_obs_reg;
  logic [CNT_W-1:0]      cnt_reg [3];
  logic [2:0]            evt;

  logic push, accept, pop, fail_now, same;

  assign exp_ready = count_reg < (PTR_W+1)'(DEPTH);
  assign push      = exp_valid && exp_ready;
  assign accept    = obs_valid && (state_reg != IDLE);
  assign pop       = accept && (count_reg != '0);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= exp_data;
  end

  // Occupancy, not pointer equality, separates full from empty.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + (PTR_W+1)'(1);
        2'b01:   count_reg <= count_reg - (PTR_W+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Stage 1: capture the popped head (registered RAM read) and the observed byte.
  // An unexpected beat carries an expected value of zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      res_valid_reg <= 1'b0;
      res_unexp_reg <= 1'b0;
      res_exp_reg   <= '0;
      res_obs_reg   <= '0;
    end else begin
      res_valid_reg <= accept;
      res_unexp_reg <= accept && !pop;
      res_exp_reg   <= pop ? mem[rd_ptr_reg] : '0;
      res_obs_reg   <= obs_data;
    end
  end

  assign same     = (res_exp_reg == res_obs_reg);
  assign evt[0]   = res_valid_reg && !res_unexp_reg && same;
  assign evt[1]   = res_valid_reg && !res_unexp_reg && !same;
  assign evt[2]   = res_valid_reg && res_unexp_reg;
  assign fail_now = evt[1] || evt[2];

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
      always_ff @(posedge clk) begin
        if (reset)
          cnt_reg[gi] <= '0;
        else if (evt[gi] && (cnt_reg[gi] != '1))
          cnt_reg[gi] <= cnt_reg[gi] + CNT_W'(1);
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      err_exp_reg <= '0;
      err_obs_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == ARMED && fail_now) begin
        err_exp_reg <= res_exp_reg;
        err_obs_reg <= res_obs_reg;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (check_en) state_next = ARMED;
      ARMED:   if (fail_now) state_next = FAIL;
               else if (!check_en) state_next = IDLE;
      FAIL:    state_next = FAIL;
      default: state_next = IDLE;
    endcase
  end

  assign match_cnt      = cnt_reg[0];
  assign mismatch_cnt   = cnt_reg[1];
  assign unexpected_cnt = cnt_reg[2];
  assign pending        = count_reg;
  assign error          = (state_reg == FAIL);
  assign err_exp        = err_exp_reg;
  assign err_obs        = err_obs_reg;
  assign idle           = (state_reg == IDLE);
endmodule

// File: tb/tb_core_response_checker.sv
// Bench for core_response_checker: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_core_response_checker;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, exp_valid, obs_valid, check_en;
  logic [7:0] exp_data, obs_data;

  logic        exp_ready, error, idle;
  logic [15:0] match_cnt, mismatch_cnt, unexpected_cnt;
  logic [3:0]  pending;
  logic [7:0]  err_exp, err_obs;

  logic        s_exp_ready, s_error, s_idle;
  logic [2:0]  s_match_cnt, s_mismatch_cnt, s_unexpected_cnt;
  logic [3:0]  s_pending;
  logic [7:0]  s_err_exp, s_err_obs;

  core_response_checker #(.DATA_W(8), .DEPTH(DEPTH), .CNT_W(16)) u_dut (
    .clk(clk), .reset(reset), .exp_valid(exp_valid), .exp_data(exp_data),
    .exp_ready(exp_ready), .obs_valid(obs_valid), .obs_data(obs_data),
    .check_en(check_en), .match_cnt(match_cnt), .mismatch_cnt(mismatch_cnt),
    .unexpected_cnt(unexpected_cnt), .pending(pending), .error(error),
    .err_exp(err_exp), .err_obs(err_obs), .idle(idle));

  // Narrow-counter copy on the same stimulus, to reach saturation quickly.
  core_response_checker #(.DATA_W(8), .DEPTH(DEPTH), .CNT_W(3)) u_sat (
    .clk(clk), .reset(reset), .exp_valid(exp_valid), .exp_data(exp_data),
    .exp_ready(s_exp_ready), .obs_valid(obs_valid), .obs_data(obs_data),
    .check_en(check_en), .match_cnt(s_match_cnt), .mismatch_cnt(s_mismatch_cnt),
    .unexpected_cnt(s_unexpected_cnt), .pending(s_pending), .error(s_error),
    .err_exp(s_err_exp), .err_obs(s_err_obs), .idle(s_idle));

  typedef enum {M_IDLE, M_ARMED, M_FAIL} mstate_t;
  mstate_t    m_st;
  logic [7:0] q[$];
  longint     m_match, m_mism, m_unexp;
  logic [7:0] m_err_exp, m_err_obs;
  bit         pipe_v, pipe_u;
  logic [7:0] pipe_e, pipe_o;

  int tests = 0;
  int fails = 0;

  function automatic longint sat(input longint v, input int w);
    longint mx = (64'd1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  task automatic chk(input string name, input longint act, input longint expv);
    tests++;
    if (act != expv) begin
      fails++;
      if (fails <= 40) $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  // Each beat is settled one edge after it is taken: a beat on an empty FIFO is
  // unexpected, otherwise the oldest expected byte is consumed and compared.
  task automatic model_update();
    bit ready, acc, fail;
    if (reset) begin
      q.delete();
      m_match = 0; m_mism = 0; m_unexp = 0;
      m_st = M_IDLE; m_err_exp = 0; m_err_obs = 0;
      pipe_v = 0; pipe_u = 0; pipe_e = 0; pipe_o = 0;
    end else begin
      ready = (q.size() < DEPTH);
      acc   = obs_valid && (m_st != M_IDLE);
      fail  = 0;
      if (pipe_v) begin
        if (pipe_u) begin m_unexp++; fail = 1; end
        else if (pipe_e == pipe_o) m_match++;
        else begin m_mism++; fail = 1; end
      end
      case (m_st)
        M_IDLE:  if (check_en) m_st = M_ARMED;
        M_ARMED: if (fail) begin m_st = M_FAIL; m_err_exp = pipe_e; m_err_obs = pipe_o; end
                 else if (!check_en) m_st = M_IDLE;
        default: m_st = M_FAIL;
      endcase
      pipe_v = acc; pipe_u = 0; pipe_e = 0; pipe_o = obs_data;
      if (acc) begin
        if (q.size() > 0) pipe_e = q.pop_front();
        else pipe_u = 1;
      end
      if (exp_valid && ready) q.push_back(exp_data);
    end
  endtask

  task automatic compare_all();
    chk("match_cnt", match_cnt, sat(m_match, 16));
    chk("mismatch_cnt", mismatch_cnt, sat(m_mism, 16));
    chk("unexpected_cnt", unexpected_cnt, sat(m_unexp, 16));
    chk("sat_match_cnt", s_match_cnt, sat(m_match, 3));
    chk("sat_mismatch_cnt", s_mismatch_cnt, sat(m_mism, 3));
    chk("sat_unexpected_cnt", s_unexpected_cnt, sat(m_unexp, 3));
    chk("pending", pending, q.size());
    chk("exp_ready", exp_ready, q.size() < DEPTH);
    chk("error", error, m_st == M_FAIL);
    chk("idle", idle, m_st == M_IDLE);
    chk("err_exp", err_exp, m_err_exp);
    chk("err_obs", err_obs, m_err_obs);
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    reset = 1; exp_valid = 0; obs_valid = 0; check_en = 0; exp_data = 0; obs_data = 0;
    @(negedge clk);

    // 1: reset held three cycles
    repeat (3) step();
    chk("t1_match", match_cnt, 0); chk("t1_pending", pending, 0);
    chk("t1_error", error, 0); chk("t1_idle", idle, 1); chk("t1_exp_ready", exp_ready, 1);
    $display("[TB] scenario 1 reset done");

    // 2: three matching beats
    reset = 0;
    exp_valid = 1;
    exp_data = 8'h00; step(); exp_data = 8'hFF; step(); exp_data = 8'h55; step();
    exp_valid = 0; check_en = 1; step();
    obs_valid = 1;
    obs_data = 8'h00; step(); obs_data = 8'hFF; step(); obs_data = 8'h55; step();
    obs_valid = 0; step();
    chk("t2_match", match_cnt, 3); chk("t2_pending", pending, 0); chk("t2_error", error, 0);
    $display("[TB] scenario 2 matches done");

    // 3: two mismatches, first one frozen
    exp_valid = 1;
    exp_data = 8'hFF; step(); exp_data = 8'h11; step();
    exp_valid = 0; obs_valid = 1;
    obs_data = 8'hAA; step(); obs_data = 8'h22; step();
    obs_valid = 0; step(); step();
    chk("t3_mismatch", mismatch_cnt, 2); chk("t3_error", error, 1);
    chk("t3_err_exp", err_exp, 8'hFF); chk("t3_err_obs", err_obs, 8'hAA); chk("t3_idle", idle, 0);
    $display("[TB] scenario 3 mismatch done");

    // 4: unexpected beat with a simultaneous push
    reset = 1; step(); reset = 0; check_en = 1; step();
    obs_valid = 1; obs_data = 8'h3C; exp_valid = 1; exp_data = 8'h3C; step();
    obs_valid = 0; exp_valid = 0; step();
    chk("t4_unexpected", unexpected_cnt, 1); chk("t4_err_exp", err_exp, 0);
    chk("t4_err_obs", err_obs, 8'h3C); chk("t4_pending", pending, 1); chk("t4_error", error, 1);
    $display("[TB] scenario 4 unexpected done");

    // 5: fill the FIFO, hold a ninth offer, release it with one pop
    reset = 1; check_en = 0; step(); reset = 0;
    exp_valid = 1;
    for (int i = 0; i < 8; i++) begin exp_data = 8'(i * 17 + 1); step(); end
    chk("t5_full_ready", exp_ready, 0); chk("t5_full_pending", pending, 8);
    exp_data = 8'h99; step();
    chk("t5_held_pending", pending, 8);
    check_en = 1; step();
    obs_valid = 1; obs_data = 8'h01; step();
    chk("t5_pop_pending", pending, 7); chk("t5_pop_ready", exp_ready, 1);
    obs_valid = 0; step();
    chk("t5_ninth_pending", pending, 8);
    exp_valid = 0;
    $display("[TB] scenario 5 full fifo done");

    // 6: disarmed, obs beats ignored
    check_en = 0; step();
    for (int i = 0; i < 6; i++) begin obs_valid = i[0]; obs_data = 8'($urandom); step(); end
    obs_valid = 0;
    chk("t6_match", match_cnt, 1); chk("t6_mismatch", mismatch_cnt, 0);
    chk("t6_pending", pending, 8); chk("t6_idle", idle, 1);
    $display("[TB] scenario 6 idle done");

    // 7: reset out of a failed, partly full state
    check_en = 1; step();
    obs_valid = 1; obs_data = 8'hEE;
    repeat (4) step();
    obs_valid = 0; step(); step();
    chk("t7_pending", pending, 4); chk("t7_error", error, 1); chk("t7_mismatch", mismatch_cnt, 4);
    chk("t7_err_exp", err_exp, 8'h12); chk("t7_err_obs", err_obs, 8'hEE);
    reset = 1; step(); reset = 0;
    chk("t7_r_match", match_cnt, 0); chk("t7_r_mismatch", mismatch_cnt, 0);
    chk("t7_r_pending", pending, 0); chk("t7_r_error", error, 0); chk("t7_r_err_exp", err_exp, 0);
    chk("t7_r_err_obs", err_obs, 0); chk("t7_r_idle", idle, 1); chk("t7_r_exp_ready", exp_ready, 1);
    $display("[TB] scenario 7 reset recovery done");

    // 8: counter saturation on the narrow instance
    check_en = 1; step();
    for (int i = 0; i < 11; i++) begin
      exp_valid = (i < 10); exp_data = 8'(i + 8'h40);
      obs_valid = (i > 0);  obs_data = 8'(i - 1 + 8'h40);
      step();
    end
    exp_valid = 0; obs_valid = 0; step(); step();
    chk("t8_sat_match", s_match_cnt, 7); chk("t8_match", match_cnt, 10);
    chk("t8_pending", pending, 0); chk("t8_error", error, 0);
    $display("[TB] scenario 8 saturation done");

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      reset     = ($urandom % 150) == 0;
      check_en  = ($urandom % 20) != 0;
      exp_valid = $urandom % 2;
      exp_data  = 8'($urandom);
      obs_valid = ($urandom % 3) != 0;
      obs_data  = (q.size() > 0 && ($urandom % 40) != 0) ? q[0] : 8'($urandom);
      step();
    end
    $display("[TB] random phase done");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
